// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - single-port instruction RAM arbiter between fetch and program loader
module imem_port_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_done_i,
  input  logic              fetch_req_i,
  input  logic [31:0]       fetch_addr_i,
  input  logic              fetch_flush_i,
  output logic              fetch_gnt_o,
  output logic              fetch_rvalid_o,
  output logic [31:0]       fetch_rdata_o,
  output logic              fetch_err_o,
  input  logic              ld_req_i,
  input  logic [31:0]       ld_addr_i,
  input  logic [31:0]       ld_wdata_i,
  output logic              ld_gnt_o,
  output logic              ld_err_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              running_o
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(BURST_MAX);

  state_t            state, state_nxt;
  logic [3:0]        burst_cnt, burst_nxt;
  logic              rsp_valid, rsp_illegal;
  logic              fetch_legal, ld_legal;
  logic [ADDR_W-1:0] fetch_word, ld_word;

  assign fetch_word  = fetch_addr_i[ADDR_W+1:2];
  assign ld_word     = ld_addr_i[ADDR_W+1:2];
  assign fetch_legal = (fetch_addr_i[1:0] == 2'b00) && (fetch_addr_i[31:ADDR_W+2] == '0);
  assign ld_legal    = (ld_addr_i[1:0] == 2'b00) && (ld_addr_i[31:ADDR_W+2] == '0);
  assign running_o   = (state == RUN);

  // Grants are held low while reset is asserted so every output reads 0 during reset.
  always_comb begin
    state_nxt   = state;
    burst_nxt   = burst_cnt;
    fetch_gnt_o = 1'b0;
    ld_gnt_o    = 1'b0;
    if (rst_n) begin
      case (state)
        BOOT: begin
          ld_gnt_o = ld_req_i;
          if (ld_done_i) state_nxt = RUN;
        end
        RUN: begin
          if (ld_req_i && fetch_req_i) begin
            ld_gnt_o    = (burst_cnt != BURST_LIMIT);
            fetch_gnt_o = !ld_gnt_o;
          end else begin
            ld_gnt_o    = ld_req_i;
            fetch_gnt_o = fetch_req_i;
          end
          if (!fetch_req_i || fetch_gnt_o) burst_nxt = 4'd0;
          else if (ld_gnt_o)               burst_nxt = burst_cnt + 4'd1;
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (ld_gnt_o) begin
      mem_en_o    = ld_legal;
      mem_we_o    = ld_legal;
      mem_addr_o  = ld_word;
      mem_wdata_o = ld_wdata_i;
    end else if (fetch_gnt_o) begin
      mem_en_o    = fetch_legal;
      mem_addr_o  = fetch_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      burst_cnt   <= 4'd0;
      rsp_valid   <= 1'b0;
      rsp_illegal <= 1'b0;
      ld_err_o    <= 1'b0;
    end else begin
      state       <= state_nxt;
      burst_cnt   <= burst_nxt;
      rsp_valid   <= fetch_gnt_o;
      rsp_illegal <= fetch_gnt_o && !fetch_legal;
      if (ld_gnt_o && !ld_legal) ld_err_o <= 1'b1;
    end
  end

  // A flush in the response cycle suppresses the response; illegal fetches return a NOP.
  assign fetch_rvalid_o = rsp_valid && !fetch_flush_i;
  assign fetch_err_o    = fetch_rvalid_o && rsp_illegal;
  assign fetch_rdata_o  = (fetch_rvalid_o && !rsp_illegal) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - scoreboard testbench for imem_port_arbiter
module tb_imem_port_arbiter;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ld_done, fetch_req, fetch_flush, ld_req;
  logic [31:0]       fetch_addr, ld_addr, ld_wdata;
  logic              fetch_gnt, fetch_rvalid, fetch_err, ld_gnt, ld_err;
  logic [31:0]       fetch_rdata, mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;
  logic              mem_en, mem_we, running;
  logic [ADDR_W-1:0] mem_addr;

  logic [31:0] ram [0:2047];
  logic [32:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  imem_port_arbiter #(.ADDR_W(ADDR_W), .BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld_done_i(ld_done),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_flush_i(fetch_flush),
    .fetch_gnt_o(fetch_gnt), .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
    .fetch_err_o(fetch_err), .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
    .ld_gnt_o(ld_gnt), .ld_err_o(ld_err), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .running_o(running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every rvalid must match the oldest expected {err, rdata}.
  always @(negedge clk) begin
    if (fetch_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rdata %h err %b expected no response", fetch_rdata, fetch_err);
      end else begin
        chk("rsp", {fetch_err, fetch_rdata}, exp_q.pop_front());
      end
    end else begin
      chk("idle_rdata", {1'b0, fetch_rdata}, 33'h0);
    end
  end

  task automatic drive(input logic fr, input logic [31:0] fa, input logic fl,
                       input logic lr, input logic [31:0] la, input logic [31:0] lw,
                       input logic dn);
    fetch_req = fr; fetch_addr = fa; fetch_flush = fl;
    ld_req = lr; ld_addr = la; ld_wdata = lw; ld_done = dn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_rvalid", {32'h0, fetch_rvalid}, 33'h0);
    chk("rst_running", {32'h0, running}, 33'h0);
    chk("rst_ld_err", {32'h0, ld_err}, 33'h0);
    chk("rst_mem_en", {31'h0, mem_en, mem_we}, 33'h0);
    chk("rst_gnts", {31'h0, fetch_gnt, ld_gnt}, 33'h0);
    tick();
    rst_n = 1'b1;

    // Boot load with fetch requesting throughout
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'h2008_0005, 1'b0);
    @(negedge clk);
    chk("boot_gnts", {31'h0, fetch_gnt, ld_gnt}, 33'h1);
    chk("boot_mem", {29'h0, mem_en, mem_we, 2'(mem_addr)}, {29'h0, 4'b1100});
    tick();
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h4, 32'h2109_0001, 1'b1);
    @(negedge clk);
    chk("boot_gnts2", {31'h0, fetch_gnt, ld_gnt}, 33'h1);
    chk("boot_running", {32'h0, running}, 33'h0);
    tick();
    idle();
    @(negedge clk);
    chk("run_running", {32'h0, running}, 33'h1);
    tick();

    // Back-to-back fetches
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("f0_gnt", {32'h0, fetch_gnt}, 33'h1);
    exp_q.push_back({1'b0, 32'h2008_0005});
    tick();
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("f1_gnt", {32'h0, fetch_gnt}, 33'h1);
    chk("f0_rvalid", {32'h0, fetch_rvalid}, 33'h1);
    exp_q.push_back({1'b0, 32'h2109_0001});
    tick();
    idle();
    @(negedge clk);
    chk("f1_rvalid", {32'h0, fetch_rvalid}, 33'h1);
    tick();

    // Fairness: L,L,L,L,F,L,L,L,L,F
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h20, 32'(i), 1'b0);
      @(negedge clk);
      if (i == 4 || i == 9) begin
        chk($sformatf("fair%0d", i), {31'h0, fetch_gnt, ld_gnt}, 33'h2);
        exp_q.push_back({1'b0, 32'h2008_0005});
      end else begin
        chk($sformatf("fair%0d", i), {31'h0, fetch_gnt, ld_gnt}, 33'h1);
      end
      tick();
    end
    idle();
    tick();

    // Illegal fetches
    drive(1'b1, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("ill_f2", {31'h0, fetch_gnt, mem_en}, 33'h2);
    exp_q.push_back({1'b1, 32'h0});
    tick();
    drive(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("ill_f2000", {31'h0, fetch_gnt, mem_en}, 33'h2);
    exp_q.push_back({1'b1, 32'h0});
    tick();

    // Illegal loader write
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk("ill_ld", {30'h0, ld_gnt, mem_en, mem_we}, 33'h4);
    tick();
    idle();
    @(negedge clk);
    chk("ld_err_set", {32'h0, ld_err}, 33'h1);
    tick();

    // Flush: first response cancelled, second fetch in flush cycle survives
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("fl_gnt0", {32'h0, fetch_gnt}, 33'h1);
    tick();
    drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("fl_gnt1", {31'h0, fetch_gnt, fetch_rvalid}, 33'h2);
    exp_q.push_back({1'b0, 32'h2109_0001});
    tick();
    idle();
    @(negedge clk);
    chk("fl_rvalid2", {32'h0, fetch_rvalid}, 33'h1);
    tick();

    // Write-then-read hazard, then confirm word 0 survived the dropped write
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    chk("hz_ld", {30'h0, ld_gnt, mem_en, mem_we}, 33'h7);
    tick();
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    tick();
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    exp_q.push_back({1'b0, 32'h2008_0005});
    tick();
    idle();
    @(negedge clk);
    chk("ld_err_sticky", {32'h0, ld_err}, 33'h1);
    tick();

    // Reset between a fetch grant and its response
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("mr_gnt", {32'h0, fetch_gnt}, 33'h1);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("mr_rvalid", {32'h0, fetch_rvalid}, 33'h0);
    chk("mr_running", {32'h0, running}, 33'h0);
    chk("mr_ld_err", {32'h0, ld_err}, 33'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk($sformatf("post_rst_gnt%0d", i), {31'h0, fetch_gnt, running}, 33'h0);
      tick();
    end
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("reboot_gnt", {31'h0, fetch_gnt, running}, 33'h3);
    exp_q.push_back({1'b0, 32'h2008_0005});
    tick();
    idle();
    repeat (3) tick();

    chk("queue_empty", 33'(exp_q.size()), 33'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
